systolic_tile_seq: RTL

Autonomous sequencer that runs one complete weight-stationary matrix tile job on the PE_ROW×PE_COL systolic array without hand-driven stimulus. It issues global-buffer read/write addresses and array controls in a fixed order: weight load, save, skewed input streaming, drain, result write-back. It adds multi-tile streaming with weight reuse and optional partial-sum accumulation. It sits between the host/config logic and the `systolic`, `systolic_input_buffer`, `systolic_output_buffer` and `global_buffer` instances.

---
 rtl/systolic_pkg.sv | 28 ++
 rtl/enable_skew_gen.sv | 26 ++
 rtl/systolic_tile_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding and default geometry for the systolic tile sequencer.
// Latency: none (declarations only). Backpressure: none.
package systolic_pkg;

    localparam int DEF_PE_ROW         = 16;
    localparam int DEF_PE_COL         = 16;
    localparam int DEF_ADDR_WIDTH     = 17;
    localparam int DEF_DRAIN_CYCLES   = 16;
    localparam int DEF_TILE_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SAVE,
        GAP,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/enable_skew_gen.sv
// Registered thermometer code for the per-row skewed enables: clear, step in one row, or fill.
// Latency: 1 cycle from control to output. Backpressure: none.
module enable_skew_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             fill,
    output logic [WIDTH-1:0] therm
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            therm <= '0;
        end else if (clear) begin
            therm <= '0;
        end else if (fill) begin
            therm <= '1;
        end else if (step) begin
            therm <= {therm[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/systolic_tile_seq.sv
// Sequences one weight-stationary job: weight load, save, skewed streaming, drain, write-back per tile.
// Latency: outputs registered, first LOAD_W cycle follows the start edge. Backpressure: none; start ignored while busy.
module systolic_tile_seq
    import systolic_pkg::*;
#(
    parameter int PE_ROW         = DEF_PE_ROW,
    parameter int PE_COL         = DEF_PE_COL,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]     cfg_in_base,
    input  logic [ADDR_WIDTH-1:0]     cfg_out_base,
    input  logic [ADDR_WIDTH-1:0]     cfg_psum_base,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
    input  logic                      cfg_accum,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     raddr_a,
    output logic [ADDR_WIDTH-1:0]     raddr_b,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic                      write,
    output logic                      load_weight,
    output logic                      save,
    output logic                      first_partial,
    output logic [PE_ROW-1:0]         enable
);

    localparam int PH_W = $clog2(max3(PE_ROW + 1, DRAIN_CYCLES, PE_COL));

    typedef logic [PH_W-1:0]           phase_t;
    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [TILE_CNT_WIDTH-1:0] tile_t;

    localparam phase_t LOAD_LAST   = phase_t'(PE_ROW - 1);
    localparam phase_t STREAM_LAST = phase_t'(PE_ROW);
    localparam phase_t DRAIN_LAST  = phase_t'(DRAIN_CYCLES - 1);
    localparam phase_t WRITE_LAST  = phase_t'(PE_COL - 1);

    state_t  state_q, state_n;
    phase_t  phase_q, phase_n;
    tile_t   tile_q, tile_n;
    addr_t   w_base_q, in_base_q, out_base_q, psum_base_q;
    addr_t   w_base_n, in_base_n, out_base_n, psum_base_n;
    tile_t   num_tiles_q;
    logic    accum_q, accum_n;
    logic    capture;
    logic    last_tile;
    logic [TILE_CNT_WIDTH:0] tile_inc;

    addr_t   row_off, col_off;
    phase_t  k_a;
    addr_t   raddr_a_n, raddr_b_n, waddr_n;
    logic    busy_n, done_n, write_n, load_weight_n, save_n, first_partial_n;
    logic    skew_clear, skew_step, skew_fill;

    assign capture     = (state_q == IDLE) && start;
    assign w_base_n    = capture ? cfg_w_base    : w_base_q;
    assign in_base_n   = capture ? cfg_in_base   : in_base_q;
    assign out_base_n  = capture ? cfg_out_base  : out_base_q;
    assign psum_base_n = capture ? cfg_psum_base : psum_base_q;
    assign accum_n     = capture ? cfg_accum     : accum_q;
    assign tile_inc    = {1'b0, tile_q} + (TILE_CNT_WIDTH + 1)'(1);
    assign last_tile   = tile_inc >= {1'b0, num_tiles_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_base_q    <= '0;
            in_base_q   <= '0;
            out_base_q  <= '0;
            psum_base_q <= '0;
            num_tiles_q <= '0;
            accum_q     <= 1'b0;
        end else if (capture) begin
            w_base_q    <= cfg_w_base;
            in_base_q   <= cfg_in_base;
            out_base_q  <= cfg_out_base;
            psum_base_q <= cfg_psum_base;
            num_tiles_q <= (cfg_num_tiles == '0) ? tile_t'(1) : cfg_num_tiles;
            accum_q     <= cfg_accum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            tile_q  <= tile_n;
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q + phase_t'(1);
        tile_n  = tile_q;
        case (state_q)
            IDLE: begin
                phase_n = '0;
                tile_n  = '0;
                if (start) state_n = LOAD_W;
            end
            LOAD_W: if (phase_q == LOAD_LAST) begin
                state_n = SAVE;
                phase_n = '0;
            end
            SAVE: begin
                state_n = GAP;
                phase_n = '0;
            end
            GAP: begin
                state_n = STREAM;
                phase_n = '0;
            end
            STREAM: if (phase_q == STREAM_LAST) begin
                state_n = DRAIN;
                phase_n = '0;
            end
            DRAIN: if (phase_q == DRAIN_LAST) begin
                state_n = WRITE;
                phase_n = '0;
            end
            WRITE: if (phase_q == WRITE_LAST) begin
                phase_n = '0;
                if (last_tile) begin
                    state_n = DONE;
                end else begin
                    // next tile reuses the weights already saved in the PEs
                    state_n = STREAM;
                    tile_n  = tile_q + tile_t'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = '0;
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        row_off         = addr_t'(tile_n) * addr_t'(PE_ROW);
        col_off         = addr_t'(tile_n) * addr_t'(PE_COL);
        k_a             = (phase_n == STREAM_LAST) ? LOAD_LAST : phase_n;
        raddr_a_n       = '0;
        raddr_b_n       = '0;
        waddr_n         = '0;
        done_n          = 1'b0;
        write_n         = 1'b0;
        load_weight_n   = 1'b0;
        save_n          = 1'b0;
        busy_n          = (state_n != IDLE);
        first_partial_n = busy_n && !accum_n;
        case (state_n)
            LOAD_W: begin
                load_weight_n = 1'b1;
                raddr_a_n     = w_base_n + addr_t'(phase_n);
            end
            SAVE: begin
                load_weight_n = 1'b1;
                save_n        = 1'b1;
            end
            STREAM: begin
                raddr_a_n = in_base_n + row_off + addr_t'(k_a);
                raddr_b_n = psum_base_n + col_off + addr_t'(phase_n);
            end
            WRITE: begin
                write_n = 1'b1;
                waddr_n = out_base_n + col_off + addr_t'(phase_n);
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            raddr_a       <= '0;
            raddr_b       <= '0;
            waddr         <= '0;
            write         <= 1'b0;
            load_weight   <= 1'b0;
            save          <= 1'b0;
            first_partial <= 1'b0;
        end else begin
            busy          <= busy_n;
            done          <= done_n;
            raddr_a       <= raddr_a_n;
            raddr_b       <= raddr_b_n;
            waddr         <= waddr_n;
            write         <= write_n;
            load_weight   <= load_weight_n;
            save          <= save_n;
            first_partial <= first_partial_n;
        end
    end

    assign skew_step  = (state_n == STREAM) && (phase_n != '0);
    assign skew_fill  = (state_n == DRAIN) || (state_n == WRITE);
    assign skew_clear = !(skew_step || skew_fill);

    enable_skew_gen #(
        .WIDTH (PE_ROW)
    ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .clear (skew_clear),
        .step  (skew_step),
        .fill  (skew_fill),
        .therm (enable)
    );

endmodule
